square_ctrl: RTL

//  Host-side controller for one 16x16 square sprite.
//  - Holds the sprite's register file: ctrl, origin, velocity, custom colour.
//  - Runs a loader FSM that fills one 256-pixel sprite-RAM frame with a selected pattern.
//  - Moves the origin once per video frame, bouncing off the screen edges.
//  - Sits between the bus slot and the square sprite source; drives its x0/y0/ctrl/color/write ports.

---
 rtl/square_ctrl_if.sv | 13 +
 rtl/square_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/square_ctrl_if.sv
// Host register port between the bus slot and square_ctrl.
// Single-cycle write strobe with no stall; reads are combinational on rd_addr.
// Ports: wr_en/wr_addr/wr_data carry writes; rd_addr selects the register; rd_data returns it.
interface square_ctrl_if;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;

    modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/square_ctrl.sv
// Host-side controller for one 16x16 square sprite: register file, origin motion, RAM loader.
// Latency: register writes land on the next clk edge; fills start one cycle after the command.
// Backpressure: none; a fill command while the loader is busy is dropped, never queued.
// Ports: clk/reset (sync, active-high); x/y scan position; host register bus (slave modport);
//        x0/y0/ctrl/color to the sprite source; we/addr_w/pixel_in sprite RAM write; busy.
module square_ctrl #(
    parameter int ADDR  = 10,
    parameter int H_MAX = 640,
    parameter int V_MAX = 480,
    parameter int SIZE  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       x,
    input  logic [10:0]       y,
    square_ctrl_if.slave      host,
    output logic [10:0]       x0,
    output logic [10:0]       y0,
    output logic [4:0]        ctrl,
    output logic [11:0]       color,
    output logic              we,
    output logic [ADDR-1:0]   addr_w,
    output logic [1:0]        pixel_in,
    output logic              busy
);

    localparam logic [10:0] X_LIM = 11'(H_MAX - SIZE);
    localparam logic [10:0] Y_LIM = 11'(V_MAX - SIZE);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t      state_q, state_d;
    logic        move_en;
    logic [3:0]  dx, dy;
    logic [10:0] px, py;
    logic [7:0]  c;
    logic [1:0]  mode_q, sid_q;
    logic        tick;
    logic        fill_cmd;
    logic [11:0] nx, ny;

    // -dx, except -8 which has no 4-bit positive counterpart and saturates to +7.
    function automatic logic [3:0] neg_sat(input logic [3:0] v);
        return (v == 4'b1000) ? 4'b0111 : (~v + 4'd1);
    endfunction

    // One pulse on entering (0,0); holding there does not retrigger.
    assign tick     = (x == 11'd0) && (y == 11'd0) && !((px == 11'd0) && (py == 11'd0));
    assign fill_cmd = host.wr_en && (host.wr_addr == 3'd5);

    // Origin is never above 624, so a 12-bit sum keeps bit 11 as the sign.
    assign nx = {1'b0, x0} + {{8{dx[3]}}, dx};
    assign ny = {1'b0, y0} + {{8{dy[3]}}, dy};

    always_ff @(posedge clk) begin
        if (reset) begin
            move_en <= 1'b0;
            ctrl    <= '0;
            x0      <= '0;
            y0      <= '0;
            dx      <= '0;
            dy      <= '0;
            color   <= '0;
            px      <= '0;
            py      <= '0;
        end else begin
            px <= x;
            py <= y;
            if (tick && move_en) begin
                if (nx[11]) begin
                    x0 <= '0;
                    dx <= neg_sat(dx);
                end else if (nx[10:0] > X_LIM) begin
                    x0 <= X_LIM;
                    dx <= neg_sat(dx);
                end else begin
                    x0 <= nx[10:0];
                end
                if (ny[11]) begin
                    y0 <= '0;
                    dy <= neg_sat(dy);
                end else if (ny[10:0] > Y_LIM) begin
                    y0 <= Y_LIM;
                    dy <= neg_sat(dy);
                end else begin
                    y0 <= ny[10:0];
                end
            end
            // Placed after motion so a host write in the tick cycle overrides it.
            if (host.wr_en) begin
                case (host.wr_addr)
                    3'd0: begin
                        move_en <= host.wr_data[5];
                        ctrl    <= host.wr_data[4:0];
                    end
                    3'd1: x0 <= (host.wr_data > 32'(X_LIM)) ? X_LIM : host.wr_data[10:0];
                    3'd2: y0 <= (host.wr_data > 32'(Y_LIM)) ? Y_LIM : host.wr_data[10:0];
                    3'd3: begin
                        dx <= host.wr_data[3:0];
                        dy <= host.wr_data[7:4];
                    end
                    3'd4: color <= host.wr_data[11:0];
                    default: ;
                endcase
            end
        end
    end

    // Loader state register plus its counter and latched command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            c       <= '0;
            mode_q  <= '0;
            sid_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && fill_cmd) begin
                mode_q <= host.wr_data[3:2];
                sid_q  <= host.wr_data[1:0];
                c      <= '0;
            end else if (state_q == FILL) begin
                c <= c + 8'd1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        we       = 1'b0;
        addr_w   = '0;
        pixel_in = 2'd0;
        busy     = (state_q != IDLE);
        unique case (state_q)
            IDLE: if (fill_cmd) state_d = FILL;
            FILL: begin
                we          = 1'b1;
                addr_w[9:0] = {sid_q, c};
                unique case (mode_q)
                    2'd0: pixel_in = 2'd2;
                    2'd1: pixel_in = (c[7:4] == 4'd0 || c[7:4] == 4'd15 ||
                                      c[3:0] == 4'd0 || c[3:0] == 4'd15) ? 2'd3 : 2'd2;
                    2'd2: pixel_in = 2'd0;
                    default: pixel_in = (c[4] ^ c[0]) ? 2'd2 : 2'd1;
                endcase
                if (c == 8'd255) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        host.rd_data = '0;
        case (host.rd_addr)
            3'd0: host.rd_data = {26'd0, move_en, ctrl};
            3'd1: host.rd_data = {21'd0, x0};
            3'd2: host.rd_data = {21'd0, y0};
            3'd3: host.rd_data = {24'd0, dy, dx};
            3'd4: host.rd_data = {20'd0, color};
            3'd6: host.rd_data = {31'd0, busy};
            default: host.rd_data = '0;
        endcase
    end

endmodule
